// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one word-addressed data memory between the core LSU
// (port 0) and the debug/DMA loader (port 1). Round-robin on contention,
// one access per grant, registered read data, and a two-cycle
// read-modify-write for partial (sub-word) stores.
module dm_arbiter #(
    parameter int DEPTH_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [3:0]  be0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [3:0]  be1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_adr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef enum logic {IDLE, RMW} state_t;

    // First byte address past the end of the memory.
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state;
    logic        last;       // port granted on the most recent contended cycle
    logic [31:0] hold_adr;   // RMW target, word aligned
    logic [31:0] hold_data;  // merged word to write in the RMW cycle

    req_t        r0, r1, sel;
    logic        pick1;
    logic        granted;
    logic        sel_oor;
    logic        sel_full;
    logic        sel_partial;
    logic [31:0] merged;

    assign r0 = '{we: we0, addr: addr0, wdata: wdata0, be: be0};
    assign r1 = '{we: we1, addr: addr1, wdata: wdata1, be: be1};

    // Arbitration: lone requester wins; on a tie the port that did not win
    // the previous tie goes. Nothing is granted in reset or during RMW.
    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1)
            pick1 = ~last;
        else
            pick1 = req1;
        sel         = pick1 ? r1 : r0;
        granted     = !reset && (state == IDLE) && (req0 || req1);
        gnt0        = granted && !pick1;
        gnt1        = granted &&  pick1;
        sel_oor     = sel.addr >= LIMIT;
        sel_full    = sel.be == 4'hF;
        sel_partial = sel.we && !sel_full && (sel.be != 4'h0) && !sel_oor;
    end

    // Byte-lane merge of new store data over the current memory word.
    for (genvar i = 0; i < 4; i++) begin : g_merge
        assign merged[8*i +: 8] = sel.be[i] ? sel.wdata[8*i +: 8] : mem_rdata[8*i +: 8];
    end

    // Memory port: RMW cycle replays the held word, otherwise the granted
    // request drives the address; only full in-range stores write directly.
    always_comb begin
        mem_adr   = {sel.addr[31:2], 2'b00};
        mem_wdata = sel.wdata;
        mem_write = granted && sel.we && sel_full && !sel_oor;
        if (state == RMW) begin
            mem_adr   = hold_adr;
            mem_wdata = hold_data;
            mem_write = !reset;
        end
    end

    // Sequencing: read-data return, error pulses, tie history and RMW entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_adr  <= '0;
            hold_data <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata     <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            case (state)
                IDLE: begin
                    if (granted) begin
                        if (req0 && req1)
                            last <= pick1;
                        if (sel_oor) begin
                            err0 <= !pick1;
                            err1 <= pick1;
                        end
                        if (!sel.we) begin
                            rvalid0 <= !pick1;
                            rvalid1 <= pick1;
                            rdata   <= sel_oor ? 32'h0 : mem_rdata;
                        end else if (sel_partial) begin
                            hold_adr  <= {sel.addr[31:2], 2'b00};
                            hold_data <= merged;
                            state     <= RMW;
                        end
                    end
                end
                RMW:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port, word-addressed data memory (combinational read, write on posedge clk) between two requesters.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Arbitrates between the ports round-robin, issues one memory access per grant, and returns registered read data.
- Converts byte-enable partial writes (sb/sh) into a two-cycle read-modify-write (RMW) on the word memory.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the memory; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address; bits [1:0] ignored
- wdata0 / wdata1  in  32  write data, byte lanes aligned to the word
- be0 / be1  in  4  byte enables; be[i] selects wdata[8i+7:8i]
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid, registered
- rdata  out  32  registered read data, shared by both ports
- err0 / err1  out  1  registered one-cycle pulse: address out of range
- mem_adr  out  32  word-aligned byte address to memory
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset values:
  - state = IDLE, last = 1 (port 0 wins the first tie), hold registers = 0.
  - rvalid0/1 = 0, err0/1 = 0, rdata = 0.
  - gnt0/1 = 0, mem_write = 0 during the reset cycle.
- States: IDLE, RMW.
- IDLE arbitration:
  - Only one request: that port wins.
  - Both requests: the port not equal to `last` wins; `last` <= winner.
  - gnt_winner = 1 in the same cycle. mem_adr = {addr[31:2], 2'b00} of the winner.
  - Requesters hold req/we/addr/wdata/be stable until they see gnt.
- Read:
  - rdata <= mem_rdata at the grant edge; rvalid_winner = 1 for exactly the next cycle.
  - be is ignored on reads.
- Full write (be = 4'hF):
  - mem_write = 1 and mem_wdata = wdata in the grant cycle.
  - No rvalid; state stays IDLE.
- Partial write (be != 4'hF and be != 0):
  - Grant cycle: read only. The merged word is captured: byte i = be[i] ? wdata byte i : mem_rdata byte i. hold_adr and hold_data are latched. Next state is RMW.
  - RMW cycle: mem_write = 1, mem_adr = hold_adr, mem_wdata = hold_data. Both gnt = 0. Next state is IDLE.
  - Total occupancy is 2 cycles. A pending request from the other port is served no earlier than the cycle after RMW.
- be = 0 write: granted, no memory write, 1 cycle.
- Out of range (addr >= 4*DEPTH_WORDS):
  - Granted as normal, but mem_write = 0 and no RMW is entered.
  - The read returns rdata = 0 with rvalid = 1.
  - err_winner pulses 1 for one cycle, aligned with where rvalid would appear.
- Back-to-back requests: a new grant is possible every cycle in IDLE. rvalid for grant N coincides with grant N+1.
- Reset during RMW: the pending write is dropped (mem_write = 0 in the reset cycle); state returns to IDLE.
- mem_write is never asserted outside a grant cycle or the RMW cycle.
- At most one gnt is high in any cycle.

Test Plan:
1. Reset, then word write from port 0: req0=1, we0=1, addr0=0x10, wdata0=0x12345678, be0=F -> gnt0 that cycle, mem_write=1, mem_adr=0x10. Then a port-0 read of 0x10 -> rvalid0 next cycle, rdata=0x12345678.
2. Byte write into that word: be0=4'b0010, addr0=0x11, wdata0=0x0000AB00 -> gnt0, one idle memory cycle, RMW cycle mem_wdata=0x1234AB78. A later read returns 0x1234AB78.
3. Contention: req0 and req1 both held high for 4 cycles, reads of 0x0 and 0x4 -> grant order 0,1,0,1; each rvalid lands on the correct port one cycle later.
4. Port 1 halfword write (be=4'b1100) while port 0 also requests -> port 0 is stalled through the RMW cycle and granted on the following cycle; gnt0 and gnt1 are never high together.
5. Out of range: req1=1, addr1=0x3000 (DEPTH 3072), write -> gnt1, mem_write stays 0, err1 pulses next cycle. A read of the same address -> rdata=0, rvalid1=1, err1=1.
6. Assert reset in the RMW cycle of a partial write to 0x20 -> no write occurs (the word keeps its old value), and all outputs return to their reset values next cycle.
